// File: rtl/fb_page_scanout_if.sv
// Framebuffer read port and page-format output stream, bundled as one interface.
// The master side is the scanout engine; the slave side is the framebuffer plus
// the downstream consumer.
interface fb_page_scanout_if;
  logic       fb_re;
  logic       fb_r_mode;
  logic [7:0] fb_r_xpos;
  logic [7:0] fb_r_ypos;
  logic       fb_r_data_valid;
  logic [7:0] fb_dout;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_page_start;
  logic       out_last;

  modport master (
    output fb_re, fb_r_mode, fb_r_xpos, fb_r_ypos,
    input  fb_r_data_valid, fb_dout,
    output out_valid, out_data, out_page_start, out_last,
    input  out_ready
  );

  modport slave (
    input  fb_re, fb_r_mode, fb_r_xpos, fb_r_ypos,
    output fb_r_data_valid, fb_dout,
    input  out_valid, out_data, out_page_start, out_last,
    output out_ready
  );
endinterface

// File: rtl/fb_page_scanout.sv
// Page-order framebuffer scanout: reads the framebuffer one 8-pixel column byte
// at a time (pages outer, columns inner) and forwards each byte unmodified on a
// valid/ready stream, marking page starts and the final byte of the frame.
module fb_page_scanout #(
  parameter int H_PIXELS = 128,
  parameter int V_PIXELS = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic cont,
  input  logic fb_ready,
  output logic busy,
  output logic frame_done,
  output logic frame_abort,
  fb_page_scanout_if.master bus
);

  localparam int PAGES = V_PIXELS / 8;
  localparam int CW    = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam logic [CW-1:0] LAST_COL  = CW'(H_PIXELS - 1);
  localparam logic [PW-1:0] LAST_PAGE = PW'(PAGES - 1);

  typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

  state_t        state;
  logic [CW-1:0] column;
  logic [PW-1:0] page;
  logic          fb_re;
  logic [7:0]    xpos;
  logic [7:0]    ypos;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_page_start;
  logic          out_last;

  logic          at_last_col;
  logic          at_last_page;
  logic [CW-1:0] next_column;
  logic [PW-1:0] next_page;

  // Row address of a page: page*8, widened before truncation so it cannot wrap.
  function automatic logic [7:0] page_row(input logic [PW-1:0] p);
    return 8'({p, 3'b000});
  endfunction

  assign at_last_col  = (column == LAST_COL);
  assign at_last_page = (page == LAST_PAGE);

  // Next scan position: column wraps to 0 at the end of a page and bumps the page.
  always_comb begin
    next_column = column + CW'(1);
    next_page   = page;
    if (at_last_col) begin
      next_column = '0;
      next_page   = page + PW'(1);
    end
  end

  // Scan state machine; all outputs registered, loss of the framebuffer abandons the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      column         <= '0;
      page           <= '0;
      fb_re          <= 1'b0;
      xpos           <= 8'd0;
      ypos           <= 8'd0;
      out_valid      <= 1'b0;
      out_data       <= 8'd0;
      out_page_start <= 1'b0;
      out_last       <= 1'b0;
      frame_done     <= 1'b0;
      frame_abort    <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (start && fb_ready) begin
            state  <= REQ;
            column <= '0;
            page   <= '0;
            xpos   <= 8'd0;
            ypos   <= 8'd0;
            fb_re  <= 1'b1;
          end
        end
        REQ: begin
          if (!fb_ready) begin
            state          <= IDLE;
            fb_re          <= 1'b0;
            out_valid      <= 1'b0;
            out_page_start <= 1'b0;
            out_last       <= 1'b0;
            frame_abort    <= 1'b1;
          end else if (bus.fb_r_data_valid) begin
            state          <= SEND;
            fb_re          <= 1'b0;
            out_valid      <= 1'b1;
            out_data       <= bus.fb_dout;
            out_page_start <= (column == '0);
            out_last       <= at_last_col && at_last_page;
          end
        end
        SEND: begin
          if (!fb_ready) begin
            state          <= IDLE;
            fb_re          <= 1'b0;
            out_valid      <= 1'b0;
            out_page_start <= 1'b0;
            out_last       <= 1'b0;
            frame_abort    <= 1'b1;
          end else if (out_valid && bus.out_ready) begin
            out_valid      <= 1'b0;
            out_page_start <= 1'b0;
            out_last       <= 1'b0;
            if (out_last) begin
              frame_done <= 1'b1;
              column     <= '0;
              page       <= '0;
              xpos       <= 8'd0;
              ypos       <= 8'd0;
              if (cont) begin
                state <= REQ;
                fb_re <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              state  <= REQ;
              fb_re  <= 1'b1;
              column <= next_column;
              page   <= next_page;
              xpos   <= 8'(next_column);
              ypos   <= page_row(next_page);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy               = (state != IDLE);
  assign bus.fb_re          = fb_re;
  assign bus.fb_r_mode      = 1'b1;
  assign bus.fb_r_xpos      = xpos;
  assign bus.fb_r_ypos      = ypos;
  assign bus.out_valid      = out_valid;
  assign bus.out_data       = out_data;
  assign bus.out_page_start = out_page_start;
  assign bus.out_last       = out_last;

endmodule
